// File: rtl/mem_bus_pkg.sv
// Shared definitions for the native memory bus arbiter: bus widths,
// FSM state encoding and the default read data for timed-out transactions.
package mem_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int IDX_W  = 3;

  localparam logic [DATA_W-1:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } bus_state_e;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: picks the first requester above
// last_grant, wrapping to the lowest index when none is found above it.
module rr_pick
  import mem_bus_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  logic found;

  // First pass covers indices above last_grant; the second pass only runs
  // when that fails and therefore lands on the lowest requester (the wrap).
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i > int'(last_grant))) begin
        gnt[i] = 1'b1;
        idx    = IDX_W'(i);
        found  = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        gnt[i] = 1'b1;
        idx    = IDX_W'(i);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one native memory bus between several masters,
// with a watchdog that force-completes hung transactions and logs the first one.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int                NUM_MASTERS    = 2,
  parameter int                TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_valid,
  input  logic [ADDR_W*NUM_MASTERS-1:0] m_addr,
  input  logic [DATA_W*NUM_MASTERS-1:0] m_wdata,
  input  logic [STRB_W*NUM_MASTERS-1:0] m_wstrb,
  output logic [NUM_MASTERS-1:0]        m_ready,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          s_valid,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [STRB_W-1:0]             s_wstrb,
  input  logic                          s_ready,
  input  logic [DATA_W-1:0]             s_rdata,
  output logic [NUM_MASTERS-1:0]        grant,
  output logic                          err_valid,
  output logic [ADDR_W-1:0]             err_addr,
  output logic [2:0]                    err_master,
  input  logic                          err_clear
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  bus_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [IDX_W-1:0]       owner_q;
  logic [IDX_W-1:0]       last_q;
  logic [CNT_W-1:0]       cnt_q;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IDX_W-1:0]       pick_idx;

  logic [ADDR_W-1:0]      owner_addr;
  logic [DATA_W-1:0]      owner_wdata;
  logic [STRB_W-1:0]      owner_wstrb;
  logic                   owner_valid;

  logic busy;
  logic timeout_hit;
  logic done_ok;
  logic done_to;
  logic aborted;

  rr_pick #(
    .N (NUM_MASTERS)
  ) u_rr_pick (
    .req        (m_valid),
    .last_grant (last_q),
    .gnt        (pick_gnt),
    .idx        (pick_idx)
  );

  // The one-hot grant doubles as mux select; zero grant in IDLE yields zeros.
  always_comb begin
    owner_addr  = '0;
    owner_wdata = '0;
    owner_wstrb = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        owner_addr  = owner_addr  | m_addr[i*ADDR_W +: ADDR_W];
        owner_wdata = owner_wdata | m_wdata[i*DATA_W +: DATA_W];
        owner_wstrb = owner_wstrb | m_wstrb[i*STRB_W +: STRB_W];
      end
    end
  end

  // A reset cycle is never treated as BUSY so an abandoned transfer cannot
  // produce a completion strobe on its way out.
  assign busy        = (state_q == BUSY) && !reset;
  assign owner_valid = |(m_valid & grant_q);
  assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);
  assign done_ok     = busy && owner_valid && s_ready;
  assign done_to     = busy && owner_valid && !s_ready && timeout_hit;
  assign aborted     = busy && !owner_valid;

  assign s_addr  = owner_addr;
  assign s_wdata = owner_wdata;
  assign s_wstrb = owner_wstrb;
  assign grant   = grant_q;

  always_comb begin
    state_d = state_q;
    s_valid = 1'b0;
    m_ready = '0;
    m_rdata = s_rdata;
    case (state_q)
      IDLE: begin
        if (|m_valid) state_d = BUSY;
      end
      BUSY: begin
        s_valid = busy && owner_valid && !done_to;
        if (done_ok || done_to) m_ready = grant_q;
        if (done_to) m_rdata = ERR_RDATA;
        if (done_ok || done_to || aborted) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Grant, round-robin pointer and watchdog counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_MASTERS - 1);
      cnt_q   <= '0;
    end else if (state_q == IDLE) begin
      if (|m_valid) begin
        grant_q <= pick_gnt;
        owner_q <= pick_idx;
      end
      cnt_q <= '0;
    end else if (state_d == IDLE) begin
      grant_q <= '0;
      last_q  <= owner_q;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // A fresh timeout beats a simultaneous clear, otherwise the first capture sticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_valid  <= 1'b0;
      err_addr   <= '0;
      err_master <= '0;
    end else if (done_to && (!err_valid || err_clear)) begin
      err_valid  <= 1'b1;
      err_addr   <= owner_addr;
      err_master <= owner_q;
    end else if (err_clear) begin
      err_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter with two masters and a
// 16-cycle watchdog; inputs change 1ns after posedge, outputs sampled at negedge.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  m_valid;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic [1:0]  m_ready;
  logic [31:0] m_rdata;
  logic        s_valid;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic [1:0]  grant;
  logic        err_valid;
  logic [31:0] err_addr;
  logic [2:0]  err_master;
  logic        err_clear;

  int errors = 0;
  int checks = 0;

  mem_bus_arbiter #(
    .NUM_MASTERS    (2),
    .TIMEOUT_CYCLES (16),
    .ERR_RDATA      (32'hDEAD_BEEF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .m_valid    (m_valid),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_wstrb    (m_wstrb),
    .m_ready    (m_ready),
    .m_rdata    (m_rdata),
    .s_valid    (s_valid),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_wstrb    (s_wstrb),
    .s_ready    (s_ready),
    .s_rdata    (s_rdata),
    .grant      (grant),
    .err_valid  (err_valid),
    .err_addr   (err_addr),
    .err_master (err_master),
    .err_clear  (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [1:0] mv, input logic srdy, input logic [31:0] srdata);
    m_valid = mv;
    s_ready = srdy;
    s_rdata = srdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    reset     = 1'b1;
    err_clear = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    m_wstrb   = '0;
    applyStimulus(2'b00, 1'b0, 32'h0);

    // Reset state
    tick();
    tick();
    sample();
    checkOutput("rst_grant",      32'(grant),      32'h0);
    checkOutput("rst_s_valid",    32'(s_valid),    32'h0);
    checkOutput("rst_m_ready",    32'(m_ready),    32'h0);
    checkOutput("rst_err_valid",  32'(err_valid),  32'h0);
    checkOutput("rst_err_addr",   err_addr,        32'h0);
    checkOutput("rst_err_master", 32'(err_master), 32'h0);

    // Single master read, slave ready on the 4th BUSY cycle
    tick();
    reset = 1'b0;
    m_addr[31:0] = 32'h2000_0010;
    m_wstrb[3:0] = 4'b0000;
    applyStimulus(2'b01, 1'b0, 32'h0);
    sample();
    checkOutput("rd_idle_s_valid", 32'(s_valid), 32'h0);
    checkOutput("rd_idle_grant",   32'(grant),   32'h0);
    tick();
    sample();
    checkOutput("rd_busy_grant",   32'(grant),   32'h1);
    checkOutput("rd_busy_s_valid", 32'(s_valid), 32'h1);
    checkOutput("rd_busy_s_addr",  s_addr,       32'h2000_0010);
    checkOutput("rd_busy_s_wstrb", 32'(s_wstrb), 32'h0);
    tick();
    tick();
    sample();
    checkOutput("rd_wait_m_ready", 32'(m_ready), 32'h0);
    tick();
    applyStimulus(2'b01, 1'b1, 32'h1234_5678);
    sample();
    checkOutput("rd_done_m_ready", 32'(m_ready), 32'h1);
    checkOutput("rd_done_m_rdata", m_rdata,      32'h1234_5678);
    tick();
    applyStimulus(2'b00, 1'b0, 32'h0);
    sample();
    checkOutput("rd_after_m_ready", 32'(m_ready), 32'h0);
    checkOutput("rd_after_grant",   32'(grant),   32'h0);

    // Contention: m0 was last served, so m1 goes first, then alternation
    m_addr[63:32] = 32'h3000_0020;
    tick();
    applyStimulus(2'b11, 1'b1, 32'hA5A5_0001);
    for (int k = 0; k < 4; k++) begin
      sample();
      checkOutput($sformatf("cont%0d_idle_grant", k),   32'(grant),   32'h0);
      checkOutput($sformatf("cont%0d_idle_m_ready", k), 32'(m_ready), 32'h0);
      tick();
      sample();
      checkOutput($sformatf("cont%0d_grant", k),   32'(grant),   (k % 2 == 0) ? 32'h2 : 32'h1);
      checkOutput($sformatf("cont%0d_m_ready", k), 32'(m_ready), (k % 2 == 0) ? 32'h2 : 32'h1);
      checkOutput($sformatf("cont%0d_s_addr", k),  s_addr,
                  (k % 2 == 0) ? 32'h3000_0020 : 32'h2000_0010);
      tick();
    end
    applyStimulus(2'b00, 1'b0, 32'h0);

    // Write pass-through from m1; m0 carries different data to expose a bad mux
    m_wdata[31:0]  = 32'h1111_1111;
    m_wstrb[3:0]   = 4'b1111;
    m_addr[63:32]  = 32'h1000_0004;
    m_wdata[63:32] = 32'hCAFE_F00D;
    m_wstrb[7:4]   = 4'b0011;
    applyStimulus(2'b10, 1'b0, 32'h0);
    sample();
    checkOutput("wr_idle_s_valid", 32'(s_valid), 32'h0);
    tick();
    sample();
    checkOutput("wr_grant",   32'(grant),   32'h2);
    checkOutput("wr_s_valid", 32'(s_valid), 32'h1);
    checkOutput("wr_s_addr",  s_addr,       32'h1000_0004);
    checkOutput("wr_s_wdata", s_wdata,      32'hCAFE_F00D);
    checkOutput("wr_s_wstrb", 32'(s_wstrb), 32'h3);
    tick();
    applyStimulus(2'b10, 1'b1, 32'h0);
    sample();
    checkOutput("wr_m_ready", 32'(m_ready), 32'h2);
    tick();
    applyStimulus(2'b00, 1'b0, 32'h0);
    m_wstrb = '0;

    // Timeout of m0 at 0x5000_0000: completion forced on the 16th BUSY cycle
    m_addr[31:0] = 32'h5000_0000;
    applyStimulus(2'b01, 1'b0, 32'h0);
    tick();
    repeat (14) tick();
    sample();
    checkOutput("to1_c15_m_ready", 32'(m_ready), 32'h0);
    checkOutput("to1_c15_s_valid", 32'(s_valid), 32'h1);
    tick();
    sample();
    checkOutput("to1_m_ready",   32'(m_ready),   32'h1);
    checkOutput("to1_m_rdata",   m_rdata,        32'hDEAD_BEEF);
    checkOutput("to1_s_valid",   32'(s_valid),   32'h0);
    checkOutput("to1_err_early", 32'(err_valid), 32'h0);
    tick();
    applyStimulus(2'b00, 1'b0, 32'h0);
    sample();
    checkOutput("to1_err_valid",  32'(err_valid),  32'h1);
    checkOutput("to1_err_addr",   err_addr,        32'h5000_0000);
    checkOutput("to1_err_master", 32'(err_master), 32'h0);
    checkOutput("to1_idle_grant", 32'(grant),      32'h0);

    // Second timeout from m1 must not overwrite the first capture
    m_addr[63:32] = 32'h6000_0000;
    tick();
    applyStimulus(2'b10, 1'b0, 32'h0);
    tick();
    repeat (15) tick();
    sample();
    checkOutput("to2_m_ready", 32'(m_ready), 32'h2);
    checkOutput("to2_m_rdata", m_rdata,      32'hDEAD_BEEF);
    tick();
    applyStimulus(2'b00, 1'b0, 32'h0);
    sample();
    checkOutput("to2_err_valid",  32'(err_valid),  32'h1);
    checkOutput("to2_err_addr",   err_addr,        32'h5000_0000);
    checkOutput("to2_err_master", 32'(err_master), 32'h0);

    // Clear the sticky flag
    tick();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    sample();
    checkOutput("clr_err_valid", 32'(err_valid), 32'h0);

    // s_ready on exactly the timeout cycle wins over the watchdog
    m_addr[31:0] = 32'h7000_0000;
    applyStimulus(2'b01, 1'b0, 32'h0);
    tick();
    repeat (14) tick();
    tick();
    applyStimulus(2'b01, 1'b1, 32'h600D_F00D);
    sample();
    checkOutput("race_m_ready", 32'(m_ready), 32'h1);
    checkOutput("race_m_rdata", m_rdata,      32'h600D_F00D);
    checkOutput("race_s_valid", 32'(s_valid), 32'h1);
    tick();
    applyStimulus(2'b00, 1'b0, 32'h0);
    sample();
    checkOutput("race_err_valid", 32'(err_valid), 32'h0);

    // Timeout from m1 at 0x8000_0000 sets the flag again
    m_addr[63:32] = 32'h8000_0000;
    tick();
    applyStimulus(2'b10, 1'b0, 32'h0);
    tick();
    repeat (15) tick();
    tick();
    applyStimulus(2'b00, 1'b0, 32'h0);
    sample();
    checkOutput("to3_err_valid",  32'(err_valid),  32'h1);
    checkOutput("to3_err_addr",   err_addr,        32'h8000_0000);
    checkOutput("to3_err_master", 32'(err_master), 32'h1);

    // err_clear coincident with a new timeout: the new capture wins
    m_addr[31:0] = 32'h9000_0000;
    tick();
    applyStimulus(2'b01, 1'b0, 32'h0);
    tick();
    repeat (15) tick();
    err_clear = 1'b1;
    sample();
    checkOutput("to4_m_ready", 32'(m_ready), 32'h1);
    tick();
    err_clear = 1'b0;
    applyStimulus(2'b00, 1'b0, 32'h0);
    sample();
    checkOutput("to4_err_valid",  32'(err_valid),  32'h1);
    checkOutput("to4_err_addr",   err_addr,        32'h9000_0000);
    checkOutput("to4_err_master", 32'(err_master), 32'h0);

    // Reset while m0 waits; m0 was last served, yet wins first after reset
    m_addr[31:0] = 32'hA000_0000;
    tick();
    applyStimulus(2'b01, 1'b0, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    sample();
    checkOutput("rstb_m_ready_in", 32'(m_ready), 32'h0);
    checkOutput("rstb_s_valid_in", 32'(s_valid), 32'h0);
    tick();
    reset = 1'b0;
    applyStimulus(2'b11, 1'b0, 32'h0);
    sample();
    checkOutput("rstb_grant",   32'(grant),   32'h0);
    checkOutput("rstb_s_valid", 32'(s_valid), 32'h0);
    checkOutput("rstb_m_ready", 32'(m_ready), 32'h0);
    checkOutput("rstb_err",     32'(err_valid), 32'h0);
    tick();
    sample();
    checkOutput("rstb_first_grant", 32'(grant), 32'h1);
    checkOutput("rstb_first_addr",  s_addr,     32'hA000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
